// File: rtl/trng_ctrl.sv
// TRNG sequencer: start/stop/fault control, warm-up discard, repetition and timeout health tests,
// and a first-word-fall-through output FIFO with registered read-side outputs.
module trng_ctrl #(
  parameter int unsigned WARMUP_WORDS   = 16,
  parameter int unsigned REP_LIMIT      = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          clear_fault,
  input  logic [31:0]                   word_in,
  input  logic                          word_valid,
  output logic                          core_en,
  output logic                          col_flush,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    state,
  output logic [1:0]                    fault_code,
  output logic [15:0]                   drop_cnt
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned WarmW = $clog2(WARMUP_WORDS + 1);
  localparam int unsigned RepW  = $clog2(REP_LIMIT + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWarmup = 2'd1,
    StRun    = 2'd2,
    StFault  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WarmW-1:0]  warm_cnt_q, warm_cnt_d;
  logic [RepW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [31:0]       last_word_q, last_word_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic [15:0]       drop_q, drop_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d, lvl_after_pop;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, core_en_q, col_flush_q;
  logic [31:0]       mem [FIFO_DEPTH];

  logic active, full, pop_req, pop, push, drop, flush;
  logic rep_match, rep_hit, to_hit;

  assign active    = (state_q == StWarmup) || (state_q == StRun);
  assign full      = (level_q == LvlW'(FIFO_DEPTH));
  assign pop_req   = (level_q != '0) && rd_ready;
  // rep_cnt_q == 0 means no reference word has been seen since entering WARMUP.
  assign rep_match = (rep_cnt_q != '0) && (word_in == last_word_q);
  assign rep_hit   = word_valid && rep_match && (rep_cnt_q == RepW'(REP_LIMIT - 1));
  assign to_hit    = !word_valid && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 2));

  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    last_word_d  = last_word_q;
    fault_code_d = fault_code_q;
    push         = 1'b0;
    drop         = 1'b0;
    flush        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d    = StWarmup;
          warm_cnt_d = '0;
          rep_cnt_d  = '0;
        end
      end
      StWarmup, StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (rep_hit) begin
          state_d      = StFault;
          fault_code_d = 2'd1;
          flush        = 1'b1;
        end else if (to_hit) begin
          state_d      = StFault;
          fault_code_d = 2'd2;
          flush        = 1'b1;
        end else if (word_valid) begin
          if (rep_match) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end else begin
            rep_cnt_d   = RepW'(1);
            last_word_d = word_in;
          end
          if (state_q == StWarmup) begin
            warm_cnt_d = warm_cnt_q + 1'b1;
            if (warm_cnt_q == WarmW'(WARMUP_WORDS - 1)) state_d = StRun;
          end else if (!full || pop_req) begin
            push = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      StFault: begin
        if (clear_fault) begin
          state_d      = StIdle;
          fault_code_d = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (!active || word_valid || (state_d != state_q)) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 1'b1;
  end

  // FIFO next state; the head word is precomputed so rd_data can be a register.
  always_comb begin
    pop           = pop_req && !flush;
    lvl_after_pop = level_q - LvlW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      level_d  = lvl_after_pop + LvlW'(push);
    end

    if (level_d == '0) begin
      rd_data_d = '0;
    end else if (push && (lvl_after_pop == '0)) begin
      rd_data_d = word_in;
    end else begin
      rd_data_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      warm_cnt_q   <= '0;
      rep_cnt_q    <= '0;
      last_word_q  <= '0;
      to_cnt_q     <= '0;
      fault_code_q <= '0;
      drop_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      core_en_q    <= 1'b0;
      col_flush_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      last_word_q  <= last_word_d;
      to_cnt_q     <= to_cnt_d;
      fault_code_q <= fault_code_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= (level_d != '0);
      core_en_q    <= (state_d == StWarmup) || (state_d == StRun);
      col_flush_q  <= (state_q == StIdle) && (state_d == StWarmup);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= word_in;
  end

  assign state      = state_q;
  assign fault_code = fault_code_q;
  assign drop_cnt   = drop_q;
  assign fifo_level = level_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign core_en    = core_en_q;
  assign col_flush  = col_flush_q;

endmodule
